// File: rtl/tick_timer_master_if.sv
// Avalon-MM bus between tick_timer_master and the 16-bit interval timer slave.
interface tick_timer_master_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/tick_timer_master.sv
// Programs and services the interval timer, turning each timeout into a game tick.
// Optional macro TICK_READBACK_EN: read status before acking and count spurious irqs.
module tick_timer_master #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter logic [31:0] MIN_PERIOD     = 32'd15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    tick_timer_master_if.master        avm,
    input  logic                       timer_irq,
    input  logic                       enable,
    input  logic [31:0]                period_in,
    input  logic                       period_load,
    output logic                       tick,
    output logic [15:0]                tick_count,
`ifdef TICK_READBACK_EN
    output logic [7:0]                 spurious_count,
`endif
    output logic                       running
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_PL   = 4'd1,
        WR_PH   = 4'd2,
        WR_CTRL = 4'd3,
        RUN     = 4'd4,
        ACK     = 4'd5,
        ACK_GAP = 4'd6,
        WR_STOP = 4'd7,
        RD_ST   = 4'd8,
        RD_WAIT = 4'd9
    } state_e;

    localparam logic [31:0] RESET_PERIOD = (DEFAULT_PERIOD > MIN_PERIOD) ? DEFAULT_PERIOD : MIN_PERIOD;

    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        if (p < MIN_PERIOD) begin
            return MIN_PERIOD;
        end else begin
            return p;
        end
    endfunction

    state_e      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        fresh_q, fresh_d;
    logic        running_q, running_d;
    logic        tick_q, tick_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        programming_s;
`ifdef TICK_READBACK_EN
    logic [7:0]  spur_q, spur_d;
    logic        unused_readdata_s;
    assign unused_readdata_s = ^avm.avm_readdata[15:1];
`else
    logic        unused_readdata_s;
    assign unused_readdata_s = ^avm.avm_readdata;
`endif

    assign programming_s = (state_q == WR_PL) || (state_q == WR_PH) || (state_q == WR_CTRL);

    // Next-state, bookkeeping and registered bus/tick outputs decoded from the next state.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        fresh_d      = fresh_q;
        running_d    = running_q;
        tick_count_d = tick_count_q;
        tick_d       = 1'b0;
        cs_d         = 1'b0;
        wn_d         = 1'b1;
        addr_d       = 3'd0;
        wdata_d      = 16'h0000;
`ifdef TICK_READBACK_EN
        spur_d       = spur_q;
`endif
        case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (enable) begin
                    state_d = WR_PL;
                    fresh_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTRL;
            WR_CTRL: begin
                state_d   = RUN;
                running_d = 1'b1;
                fresh_d   = 1'b0;
                if (fresh_q) begin
                    tick_count_d = 16'd0;
                end else begin
                    tick_count_d = tick_count_q;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = WR_STOP;
                end else if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = WR_PL;
                end else if (timer_irq) begin
`ifdef TICK_READBACK_EN
                    state_d = RD_ST;
`else
                    state_d = ACK;
`endif
                end else begin
                    state_d = RUN;
                end
            end
`ifdef TICK_READBACK_EN
            RD_ST:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (avm.avm_readdata[0]) begin
                    state_d = ACK;
                end else begin
                    state_d = ACK_GAP;
                    if (spur_q != 8'hFF) begin
                        spur_d = spur_q + 8'd1;
                    end else begin
                        spur_d = spur_q;
                    end
                end
            end
`endif
            ACK:     state_d = ACK_GAP;
            // The gap lets the slave's registered irq fall before RUN samples it again.
            ACK_GAP: state_d = RUN;
            WR_STOP: begin
                state_d   = IDLE;
                running_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A load also set during the RUN->WR_PL edge keeps pending, so no new value is lost.
        if (period_load) begin
            shadow_d = clamp_period(period_in);
            if (running_q || programming_s) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_d;
            end
        end else begin
            shadow_d = shadow_d;
        end

        case (state_d)
            WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = shadow_d[15:0];
            end
            WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = shadow_d[31:16];
            end
            WR_CTRL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007;
            end
            ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;
                tick_d       = 1'b1;
                tick_count_d = tick_count_q + 16'd1;
            end
            WR_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;
            end
            RD_ST: begin
                cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;
            end
            default: begin
                cs_d = 1'b0; wn_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;
            end
        endcase
    end

    // State and output registers; reset idles the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shadow_q     <= RESET_PERIOD;
            pending_q    <= 1'b0;
            fresh_q      <= 1'b0;
            running_q    <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= 16'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
`ifdef TICK_READBACK_EN
            spur_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            fresh_q      <= fresh_d;
            running_q    <= running_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef TICK_READBACK_EN
            spur_q       <= spur_d;
`endif
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write_n    = wn_q;
    assign avm.avm_writedata  = wdata_q;
    assign tick               = tick_q;
    assign tick_count         = tick_count_q;
    assign running            = running_q;
`ifdef TICK_READBACK_EN
    assign spurious_count     = spur_q;
`endif

endmodule
